// File: rtl/direction_indicator.sv
// direction_indicator: registered N-way direction display with a hold
// filter against direction glitches, an optional blinking active digit and
// a one-cycle pulse on every committed direction change.
module direction_indicator #(
  parameter int NUM_DIR      = 4,
  parameter int DIR_W        = $clog2(NUM_DIR),
  parameter int HOLD_CYCLES  = 5_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DIR_W-1:0]        direc,
  input  logic                    blink_en,
  output logic [NUM_DIR-1:0][6:0] hex,
  output logic [DIR_W-1:0]        active_dir,
  output logic                    changed
);

  // hold_cnt only ever holds 0..HOLD_CYCLES-1
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BLINK_W = $clog2(BLINK_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [6:0]         BLANK      = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHOW, PENDING} state_t;

  // Segment pattern {g,f,e,d,c,b,a}, active-low, for a direction code.
  function automatic logic [6:0] glyph(input int code);
    case (code)
      0: return 7'b0101111;  // r
      1: return 7'b1000111;  // L
      2: return 7'b0001110;  // F
      3: return 7'b0000011;  // b
      default: begin
        case (code % 16)
          0:  return 7'h40;
          1:  return 7'h79;
          2:  return 7'h24;
          3:  return 7'h30;
          4:  return 7'h19;
          5:  return 7'h12;
          6:  return 7'h02;
          7:  return 7'h78;
          8:  return 7'h00;
          9:  return 7'h10;
          10: return 7'h08;
          11: return 7'h03;
          12: return 7'h46;
          13: return 7'h21;
          14: return 7'h06;
          default: return 7'h0E;
        endcase
      end
    endcase
  endfunction

  state_t               state_reg, state_next;
  logic [DIR_W-1:0]     cand_reg, cand_next;
  logic [HOLD_W-1:0]    hold_cnt_reg, hold_cnt_next;
  logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
  logic                 phase_hidden_reg, phase_hidden_next;
  logic [DIR_W-1:0]     active_next;
  logic                 changed_next;
  logic                 commit;
  logic                 direc_valid;
  logic                 show_active;
  logic [NUM_DIR-1:0][6:0] hex_next;

  // Codes outside the direction range mean "no change".
  assign direc_valid = (int'(direc) < NUM_DIR);

  // State register; every output is registered here from its next value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cand_reg         <= '0;
      hold_cnt_reg     <= '0;
      blink_cnt_reg    <= '0;
      phase_hidden_reg <= 1'b0;
      active_dir       <= '0;
      changed          <= 1'b0;
      hex              <= {NUM_DIR{BLANK}};
    end else begin
      state_reg        <= state_next;
      cand_reg         <= cand_next;
      hold_cnt_reg     <= hold_cnt_next;
      blink_cnt_reg    <= blink_cnt_next;
      phase_hidden_reg <= phase_hidden_next;
      active_dir       <= active_next;
      changed          <= changed_next;
      hex              <= hex_next;
    end
  end

  // Next-state logic: hold filter, commit decision and blink timing.
  always_comb begin
    state_next        = state_reg;
    cand_next         = cand_reg;
    hold_cnt_next     = hold_cnt_reg;
    blink_cnt_next    = blink_cnt_reg;
    phase_hidden_next = phase_hidden_reg;
    active_next       = active_dir;
    changed_next      = 1'b0;
    commit            = 1'b0;
    if (!enable) begin
      // Disable wins over everything; the committed direction is kept.
      state_next     = IDLE;
      cand_next      = '0;
      hold_cnt_next  = '0;
      blink_cnt_next = '0;
    end else begin
      // Blink counter free-runs whenever a digit is being displayed.
      if (state_reg != IDLE) begin
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_next    = '0;
          phase_hidden_next = ~phase_hidden_reg;
        end else begin
          blink_cnt_next = blink_cnt_reg + 1'b1;
        end
      end
      case (state_reg)
        IDLE: begin
          // First valid code after enabling is shown without any hold.
          if (direc_valid) begin
            commit     = 1'b1;
            state_next = SHOW;
          end
        end
        SHOW: begin
          if (direc_valid && direc != active_dir) begin
            if (HOLD_CYCLES == 1) begin
              commit = 1'b1;
            end else begin
              cand_next     = direc;
              hold_cnt_next = HOLD_W'(1);
              state_next    = PENDING;
            end
          end
        end
        PENDING: begin
          if (direc_valid) begin
            if (direc == cand_reg) begin
              if (hold_cnt_reg == HOLD_LAST) begin
                commit     = 1'b1;
                state_next = SHOW;
              end else begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
              end
            end else if (direc == active_dir) begin
              state_next = SHOW;
            end else begin
              cand_next     = direc;
              hold_cnt_next = HOLD_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
      if (commit) begin
        active_next       = direc;
        changed_next      = 1'b1;
        phase_hidden_next = 1'b0;
        blink_cnt_next    = '0;
        hold_cnt_next     = '0;
      end
    end
  end

  // Output logic: the active digit is lit unless idle or in the hidden blink phase.
  always_comb begin
    show_active = (state_next != IDLE) && !(blink_en && phase_hidden_next);
  end

  for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_digit
    localparam logic [6:0] GLYPH = glyph(gi);
    assign hex_next[gi] = (show_active && active_next == DIR_W'(gi)) ? GLYPH : BLANK;
  end

endmodule

// File: tb/tb_direction_indicator.sv
// tb_direction_indicator: randomized and directed checks of direction_indicator
// against a behavioural model built from runs of identical samples and the
// elapsed time since the last commit.
module tb_direction_indicator;

  localparam int NUM_DIR = 4;
  localparam int HOLD    = 3;
  localparam int BLINK   = 4;

  logic            clk = 1'b0;
  logic            reset, enable, blink_en;
  logic [1:0]      direc;
  logic [3:0][6:0] hex;
  logic [1:0]      active_dir;
  logic            changed;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [1:0] m_active  = 2'd0;
  logic       m_changed = 1'b0;
  logic       m_idle    = 1'b1;
  logic       m_pending = 1'b0;
  logic       m_blink   = 1'b0;
  logic [1:0] m_cand    = 2'd0;
  int         m_run     = 0;
  int         m_since   = 0;
  logic [6:0] glyph_tab [4];

  direction_indicator #(
    .NUM_DIR(NUM_DIR), .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .direc(direc),
    .blink_en(blink_en), .hex(hex), .active_dir(active_dir), .changed(changed)
  );

  always #5 clk = ~clk;

  // Expected display from the model: the active digit is hidden during
  // every odd BLINK-long window since the last commit.
  function automatic logic [3:0][6:0] model_hex();
    logic [3:0][6:0] h;
    for (int d = 0; d < 4; d++) h[d] = 7'h7F;
    if (!m_idle && !(m_blink && ((m_since / BLINK) % 2 == 1)))
      h[m_active] = glyph_tab[m_active];
    return h;
  endfunction

  // Apply one input vector across one rising edge and advance the model.
  task automatic drive(input logic r, input logic e, input logic [1:0] d, input logic b);
    reset = r; enable = e; direc = d; blink_en = b;
    @(posedge clk);
    m_blink = b;
    if (r) begin
      m_active = 2'd0; m_changed = 1'b0; m_idle = 1'b1;
      m_pending = 1'b0; m_run = 0; m_since = 0;
    end else if (!e) begin
      m_idle = 1'b1; m_changed = 1'b0; m_pending = 1'b0; m_run = 0;
    end else begin
      m_changed = 1'b0;
      if (m_idle) begin
        m_idle = 1'b0; m_active = d; m_changed = 1'b1; m_since = 0;
      end else begin
        m_since++;
        if (d == m_active) begin
          m_pending = 1'b0;
        end else begin
          if (!m_pending || d != m_cand) begin
            m_pending = 1'b1; m_cand = d; m_run = 1;
          end else begin
            m_run++;
          end
          if (m_run >= HOLD) begin
            m_active = d; m_changed = 1'b1; m_since = 0;
            m_pending = 1'b0; m_run = 0;
          end
        end
      end
    end
    #1;
    $display("txn t=%0t rst=%0b en=%0b dir=%0d blink=%0b -> hex=%h active=%0d changed=%0b",
             $time, r, e, d, b, hex, active_dir, changed);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 2'd0, 1'b0);
      vectors++;
      if ({hex, active_dir, changed} !== {{4{7'h7F}}, 2'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL test_reset: hex=%h dir=%0d chg=%0b, expected all 7F, 0, 0", hex, active_dir, changed);
      end
    end
  endtask

  task automatic test_enable_commit();
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    vectors++;
    if ({hex, active_dir, changed} !== {7'h7F, 7'b0001110, 7'h7F, 7'h7F, 2'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL test_enable_commit first edge: hex=%h dir=%0d chg=%0b, expected F on digit 2, 2, 1", hex, active_dir, changed);
    end
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    vectors++;
    if ({hex, active_dir, changed} !== {model_hex(), m_active, m_changed} || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL test_enable_commit pulse end: hex=%h dir=%0d chg=%0b, expected hex=%h dir=%0d chg=0", hex, active_dir, changed, model_hex(), m_active);
    end
  endtask

  task automatic test_hold_change();
    logic [1:0] seq [10] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, seq[i], 1'b0);
      vectors++;
      if ({hex, active_dir, changed} !== {model_hex(), m_active, m_changed}) begin
        miscompares++;
        $display("FAIL test_hold_change step %0d: hex=%h dir=%0d chg=%0b, expected hex=%h dir=%0d chg=%0b", i, hex, active_dir, changed, model_hex(), m_active, m_changed);
      end
      if (i == 2) begin
        vectors++;
        if ({hex[1], hex[2], changed} !== {7'b1000111, 7'h7F, 1'b1}) begin
          miscompares++;
          $display("FAIL test_hold_change commit: hex1=%h hex2=%h chg=%0b, expected 47 7F 1", hex[1], hex[2], changed);
        end
      end
      if (i >= 6) begin
        vectors++;
        if ({active_dir, changed, hex[2]} !== {2'd2, 1'b0, 7'b0001110}) begin
          miscompares++;
          $display("FAIL test_hold_change glitch step %0d: dir=%0d chg=%0b hex2=%h, expected 2 0 0E", i, active_dir, changed, hex[2]);
        end
      end
    end
  endtask

  task automatic test_retarget();
    logic [1:0] seq [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, seq[i], 1'b0);
      vectors++;
      if ({hex, active_dir, changed} !== {model_hex(), m_active, m_changed}) begin
        miscompares++;
        $display("FAIL test_retarget step %0d: hex=%h dir=%0d chg=%0b, expected hex=%h dir=%0d chg=%0b", i, hex, active_dir, changed, model_hex(), m_active, m_changed);
      end
      if (i >= 3) begin
        vectors++;
        if (i < 6 && {active_dir, changed} !== {2'd0, 1'b0}) begin
          miscompares++;
          $display("FAIL test_retarget early step %0d: dir=%0d chg=%0b, expected 0 0", i, active_dir, changed);
        end else if (i == 6 && {hex[3], active_dir, changed} !== {7'b0000011, 2'd3, 1'b1}) begin
          miscompares++;
          $display("FAIL test_retarget commit: hex3=%h dir=%0d chg=%0b, expected 03 3 1", hex[3], active_dir, changed);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [6:0] want;
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 1'b1, 2'd0, 1'b1);
      if (i >= 2) begin
        want = (((i - 2) / 4) % 2 == 0) ? 7'b0101111 : 7'h7F;
        vectors++;
        if (hex[0] !== want || {hex, active_dir, changed} !== {model_hex(), m_active, m_changed}) begin
          miscompares++;
          $display("FAIL test_blink k=%0d: hex=%h dir=%0d chg=%0b, expected hex0=%h model hex=%h", i - 2, hex, active_dir, changed, want, model_hex());
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 2'd0, 1'b0);
      vectors++;
      if (hex[0] !== 7'b0101111 || {hex, active_dir, changed} !== {model_hex(), m_active, m_changed}) begin
        miscompares++;
        $display("FAIL test_blink steady %0d: hex=%h, expected hex0=2F", i, hex);
      end
    end
  endtask

  task automatic test_enable_drop();
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    drive(1'b0, 1'b0, 2'd2, 1'b0);
    vectors++;
    if ({hex, changed} !== {{4{7'h7F}}, 1'b0} || active_dir !== 2'd0) begin
      miscompares++;
      $display("FAIL test_enable_drop blank: hex=%h dir=%0d chg=%0b, expected all 7F, 0, 0", hex, active_dir, changed);
    end
    drive(1'b0, 1'b1, 2'd3, 1'b0);
    vectors++;
    if ({hex, active_dir, changed} !== {7'b0000011, 7'h7F, 7'h7F, 7'h7F, 2'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL test_enable_drop reenable: hex=%h dir=%0d chg=%0b, expected b on digit 3, 3, 1", hex, active_dir, changed);
    end
    drive(1'b0, 1'b0, 2'd3, 1'b0);
    vectors++;
    if ({hex, active_dir, changed} !== {{4{7'h7F}}, 2'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL test_enable_drop pulse drop: hex=%h dir=%0d chg=%0b, expected all 7F, 3, 0", hex, active_dir, changed);
    end
  endtask

  task automatic test_reset_pending();
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    drive(1'b1, 1'b1, 2'd1, 1'b0);
    vectors++;
    if ({hex, active_dir, changed} !== {{4{7'h7F}}, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL test_reset_pending at reset: hex=%h dir=%0d chg=%0b, expected all 7F, 0, 0", hex, active_dir, changed);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'd1, 1'b0);
      vectors++;
      if ({hex, active_dir, changed} !== {{4{7'h7F}}, 2'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL test_reset_pending idle %0d: hex=%h dir=%0d chg=%0b, expected all 7F, 0, 0", i, hex, active_dir, changed);
      end
    end
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    vectors++;
    if ({hex, active_dir, changed} !== {model_hex(), m_active, m_changed}) begin
      miscompares++;
      $display("FAIL test_reset_pending enable: hex=%h dir=%0d chg=%0b, expected hex=%h dir=%0d chg=%0b", hex, active_dir, changed, model_hex(), m_active, m_changed);
    end
  endtask

  task automatic test_random();
    logic [1:0] d = 2'd0;
    logic       b = 1'b0;
    logic       e, r;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) d = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) b = ~b;
      e = ($urandom_range(19) != 0);
      r = ($urandom_range(79) == 0);
      drive(r, e, d, b);
      vectors++;
      if ({hex, active_dir, changed} !== {model_hex(), m_active, m_changed}) begin
        miscompares++;
        $display("FAIL test_random step %0d: hex=%h dir=%0d chg=%0b, expected hex=%h dir=%0d chg=%0b", i, hex, active_dir, changed, model_hex(), m_active, m_changed);
      end
    end
  endtask

  initial begin
    glyph_tab[0] = 7'b0101111;
    glyph_tab[1] = 7'b1000111;
    glyph_tab[2] = 7'b0001110;
    glyph_tab[3] = 7'b0000011;
    reset = 1'b1; enable = 1'b0; direc = 2'd0; blink_en = 1'b0;
    test_reset();
    test_enable_commit();
    test_hold_change();
    test_retarget();
    test_blink();
    test_enable_drop();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
